// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU execute-stage units.
package cpu16_pkg;
   localparam int DATA_W    = 16;
   localparam int MUL_ITERS = 16;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;
endpackage

// File: rtl/sixteen_bit_adder.sv
// 16-bit ripple-carry adder with carry-in, carry-out and signed-overflow flag.
module sixteen_bit_adder (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        Co,
   output logic        V
);
   logic [16:0] w_c;

   assign w_c[0] = Cin;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_fa
         assign S[gi]     = A[gi] ^ B[gi] ^ w_c[gi];
         assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
      end
   endgenerate

   assign Co = w_c[16];
   // Overflow when the carry into the sign bit differs from the carry out of it.
   assign V  = w_c[16] ^ w_c[15];
endmodule

// File: rtl/seq_multiplier_16.sv
// Unsigned 16x16->32 shift-add multiplier, one partial product per clock,
// using the shared sixteen_bit_adder as its only arithmetic resource.
module seq_multiplier_16
   import cpu16_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] product
);
   mul_state_t          r_state;
   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mq;
   logic [DATA_W-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_done;
   logic [2*DATA_W-1:0] r_product;

   logic [DATA_W-1:0]   w_b_op;
   logic [DATA_W-1:0]   w_sum;
   logic                w_co;
   logic                w_unused_v;

   assign w_b_op = r_mq[0] ? r_mcand : '0;

   sixteen_bit_adder u_adder (
      .A   (r_acc),
      .B   (w_b_op),
      .Cin (1'b0),
      .S   (w_sum),
      .Co  (w_co),
      .V   (w_unused_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mq      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_mcand   <= a;
                  r_mq      <= b;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_product <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= CALC;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            CALC: begin
               // 33-bit right shift of {carry, sum, mq}.
               r_acc <= {w_co, w_sum[DATA_W-1:1]};
               r_mq  <= {w_sum[0], r_mq[DATA_W-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(MUL_ITERS - 1)) begin
                  r_product <= {w_co, w_sum, r_mq[DATA_W-1:1]};
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;
endmodule
